// File: rtl/audio_pkg.sv
// Shared audio definitions: effect indices, note-entry layout and the sound-effect note ROM.
package audio_pkg;

    localparam int FREQ_W = 24;
    localparam int DUR_W  = 16;

    localparam logic [1:0] SFX_LASER   = 2'd0;
    localparam logic [1:0] SFX_EXPLODE = 2'd1;
    localparam logic [1:0] SFX_HIT     = 2'd2;
    localparam logic [1:0] SFX_COIN    = 2'd3;

    typedef struct packed {
        logic [FREQ_W-1:0] freq;
        logic [DUR_W-1:0]  dur;
    } sfx_entry_t;

    localparam sfx_entry_t END_MARKER = '{freq: '0, dur: '0};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PLAY
    } seq_state_t;

    function automatic sfx_entry_t note(input int f, input int d);
        sfx_entry_t e;
        e.freq = FREQ_W'(f);
        e.dur  = DUR_W'(d);
        return e;
    endfunction

    // freq==0 with dur!=0 is a rest; freq!=0 with dur==0 is skipped by the sequencer.
    function automatic sfx_entry_t sfx_rom(input logic [1:0] sel, input logic [3:0] idx);
        sfx_entry_t e;
        e = END_MARKER;
        case (sel)
            SFX_LASER: begin
                case (idx)
                    4'd0:    e = note(1760, 20);
                    4'd1:    e = note(1320, 20);
                    4'd2:    e = note(880, 40);
                    default: e = END_MARKER;
                endcase
            end
            SFX_EXPLODE: begin
                case (idx)
                    4'd0:    e = note(110, 50);
                    4'd1:    e = note(0, 20);
                    4'd2:    e = note(82, 80);
                    default: e = END_MARKER;
                endcase
            end
            SFX_HIT: begin
                case (idx)
                    4'd0:    e = note(440, 0);
                    4'd1:    e = note(660, 10);
                    default: e = END_MARKER;
                endcase
            end
            SFX_COIN: e = note(988, 5);
            default:  e = END_MARKER;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/sfx_note_sequencer_tick_gen.sv
// Duration tick generator: one-cycle pulse every TICK_DIV cycles, restarted by i_clr.
// Latency: first pulse on the TICK_DIV-th cycle after i_clr drops.
// Backpressure: none; free-running while i_clr is low.
module tick_gen #(
    parameter int TICK_DIV = 12
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    output logic o_tick
);

    localparam int              CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else if (i_clr || (cnt_q == LAST)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign o_tick = !i_clr && (cnt_q == LAST);

endmodule

// File: rtl/sfx_note_sequencer.sv
// Sound-effect sequencer: walks a per-effect note ROM and drives tone frequency and gate.
// Latency: trigger sampled at one edge, LOAD next cycle, first note visible the cycle after.
// Backpressure: none; a trigger while busy aborts the running effect and restarts.
module sfx_note_sequencer
    import audio_pkg::*;
#(
    parameter int                CLK_FREQ  = 12000000,
    parameter int                TICK_HZ   = 1000,
    parameter logic [FREQ_W-1:0] IDLE_FREQ = 24'd1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_trigger,
    input  logic [1:0]        i_sfx_sel,
    output logic [FREQ_W-1:0] o_freq,
    output logic              o_gate,
    output logic              o_busy,
    output logic              o_done
);

    // Must be at least 2 so the tick counter has a distinct wrap cycle.
    localparam int TICK_DIV = CLK_FREQ / TICK_HZ;

    seq_state_t       state_q, state_d;
    logic [1:0]       sel_q;
    logic [4:0]       idx_q;
    logic [DUR_W-1:0] dur_q;
    logic             tick;
    sfx_entry_t       entry;
    logic             is_end, is_skip;
    logic             start, accept, finish, advance;

    assign entry = sfx_rom(sel_q, idx_q[3:0]);

    // idx_q[4] set means all 16 entries were consumed without an end marker.
    assign is_end  = idx_q[4] || ((entry.freq == '0) && (entry.dur == '0));
    assign is_skip = !idx_q[4] && (entry.freq != '0) && (entry.dur == '0);

    tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_clr  (state_q != ST_PLAY),
        .o_tick (tick)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        accept  = 1'b0;
        finish  = 1'b0;
        advance = 1'b0;
        o_done  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_trigger) begin
                    start   = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (i_trigger) begin
                    start   = 1'b1;
                    state_d = ST_LOAD;
                end else if (is_end) begin
                    finish  = 1'b1;
                    o_done  = 1'b1;
                    state_d = ST_IDLE;
                end else if (is_skip) begin
                    advance = 1'b1;
                end else begin
                    accept  = 1'b1;
                    state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (i_trigger) begin
                    start   = 1'b1;
                    state_d = ST_LOAD;
                end else if (tick && (dur_q == DUR_W'(1))) begin
                    advance = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sel_q  <= '0;
            idx_q  <= '0;
            dur_q  <= '0;
            o_freq <= IDLE_FREQ;
            o_gate <= 1'b0;
        end else if (start) begin
            sel_q  <= i_sfx_sel;
            idx_q  <= '0;
            o_freq <= IDLE_FREQ;
            o_gate <= 1'b0;
        end else begin
            if (advance) begin
                idx_q <= idx_q + 5'd1;
            end
            if (accept) begin
                dur_q  <= entry.dur;
                o_freq <= (entry.freq != '0) ? entry.freq : IDLE_FREQ;
                o_gate <= (entry.freq != '0);
            end else if ((state_q == ST_PLAY) && tick) begin
                dur_q <= dur_q - DUR_W'(1);
            end
            if (finish) begin
                o_freq <= IDLE_FREQ;
                o_gate <= 1'b0;
            end
        end
    end

    assign o_busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sfx_note_sequencer.sv
// Directed bench: expected output segments are queued per effect and checked by a negedge monitor.
module tb_sfx_note_sequencer;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_trigger;
    logic [1:0]  i_sfx_sel;
    logic [23:0] o_freq;
    logic        o_gate;
    logic        o_busy;
    logic        o_done;

    int n_cmp  = 0;
    int n_fail = 0;
    int done_cycles = 0;

    typedef struct {
        logic [23:0] f;
        logic        g;
        int          len;
    } seg_t;

    seg_t exp_q[$];

    logic [23:0] run_f;
    logic        run_g;
    int          run_len = 0;

    sfx_note_sequencer #(
        .CLK_FREQ (12000),
        .TICK_HZ  (1000),
        .IDLE_FREQ(24'd1)
    ) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_trigger(i_trigger),
        .i_sfx_sel(i_sfx_sel),
        .o_freq   (o_freq),
        .o_gate   (o_gate),
        .o_busy   (o_busy),
        .o_done   (o_done)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_seg(input logic [23:0] f, input logic g, input int len);
        seg_t s;
        s.f = f;
        s.g = g;
        s.len = len;
        exp_q.push_back(s);
    endtask

    task automatic close_run();
        seg_t s;
        if (exp_q.size() == 0) begin
            check("unexpected_segment_freq", {8'd0, run_f}, 32'hFFFF_FFFF);
        end else begin
            s = exp_q.pop_front();
            check("seg_freq", {8'd0, run_f}, {8'd0, s.f});
            check("seg_gate", {31'd0, run_g}, {31'd0, s.g});
            check("seg_len", run_len, s.len);
        end
    endtask

    // A segment is a run of constant (freq, gate) while busy; it also closes when busy falls.
    always @(negedge i_clk) begin
        if (o_busy === 1'b1) begin
            if ((run_len > 0) && ((o_freq !== run_f) || (o_gate !== run_g))) begin
                close_run();
                run_len = 0;
            end
            if (run_len == 0) begin
                run_f = o_freq;
                run_g = o_gate;
            end
            run_len++;
        end else if (run_len > 0) begin
            close_run();
            run_len = 0;
        end
        if (o_done === 1'b1) done_cycles++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic pulse_trigger(input logic [1:0] sel);
        i_sfx_sel = sel;
        i_trigger = 1'b1;
        @(posedge i_clk);
        #1;
        i_trigger = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick(1);
            if (o_busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        check(tag, {31'd0, ok}, 32'd1);
    endtask

    initial begin
        i_rst_n   = 1'b0;
        i_trigger = 1'b0;
        i_sfx_sel = 2'd0;
        tick(3);
        check("rst_freq", {8'd0, o_freq}, 32'd1);
        check("rst_gate", {31'd0, o_gate}, 32'd0);
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_done", {31'd0, o_done}, 32'd0);
        i_rst_n = 1'b1;
        tick(100);
        check("idle_freq", {8'd0, o_freq}, 32'd1);
        check("idle_gate", {31'd0, o_gate}, 32'd0);
        check("idle_busy", {31'd0, o_busy}, 32'd0);
        check("idle_no_done", done_cycles, 0);

        // Each note shows for dur*12 PLAY cycles plus the following LOAD, which holds it.
        push_seg(24'd1, 1'b0, 1);
        push_seg(24'd1760, 1'b1, 20 * 12 + 1);
        push_seg(24'd1320, 1'b1, 20 * 12 + 1);
        push_seg(24'd880, 1'b1, 40 * 12 + 1);
        pulse_trigger(2'd0);
        check("laser_load_busy", {31'd0, o_busy}, 32'd1);
        check("laser_load_gate", {31'd0, o_gate}, 32'd0);
        tick(1);
        check("laser_first_freq", {8'd0, o_freq}, 32'd1760);
        check("laser_first_gate", {31'd0, o_gate}, 32'd1);
        wait_idle("laser_finish", 2000);
        check("laser_done", done_cycles, 1);
        check("laser_end_freq", {8'd0, o_freq}, 32'd1);
        check("laser_end_gate", {31'd0, o_gate}, 32'd0);

        push_seg(24'd1, 1'b0, 1);
        push_seg(24'd110, 1'b1, 50 * 12 + 1);
        push_seg(24'd1, 1'b0, 20 * 12 + 1);
        push_seg(24'd82, 1'b1, 80 * 12 + 1);
        pulse_trigger(2'd1);
        tick(1);
        check("explode_first_freq", {8'd0, o_freq}, 32'd110);
        wait_idle("explode_finish", 3000);
        check("explode_done", done_cycles, 2);

        // The skipped 440 entry costs an extra LOAD with idle outputs.
        push_seg(24'd1, 1'b0, 2);
        push_seg(24'd660, 1'b1, 10 * 12 + 1);
        pulse_trigger(2'd2);
        tick(1);
        check("hit_skip_freq", {8'd0, o_freq}, 32'd1);
        check("hit_skip_gate", {31'd0, o_gate}, 32'd0);
        tick(1);
        check("hit_first_freq", {8'd0, o_freq}, 32'd660);
        wait_idle("hit_finish", 500);
        check("hit_done", done_cycles, 3);

        // Sixteen identical notes merge into one run; the 17th LOAD is the index-wrap end.
        push_seg(24'd1, 1'b0, 1);
        push_seg(24'd988, 1'b1, 16 * (5 * 12 + 1));
        pulse_trigger(2'd3);
        tick(1);
        check("coin_first_freq", {8'd0, o_freq}, 32'd988);
        wait_idle("coin_finish", 2000);
        check("coin_done", done_cycles, 4);
        check("coin_busy", {31'd0, o_busy}, 32'd0);

        // Laser aborted at cycle 300 after its trigger: 1320 ran 243..300, explode starts at 302.
        push_seg(24'd1, 1'b0, 1);
        push_seg(24'd1760, 1'b1, 20 * 12 + 1);
        push_seg(24'd1320, 1'b1, 58);
        push_seg(24'd1, 1'b0, 1);
        push_seg(24'd110, 1'b1, 99);
        pulse_trigger(2'd0);
        tick(299);
        check("abort_pre_freq", {8'd0, o_freq}, 32'd1320);
        pulse_trigger(2'd1);
        check("abort_load_gate", {31'd0, o_gate}, 32'd0);
        check("abort_load_freq", {8'd0, o_freq}, 32'd1);
        check("abort_load_busy", {31'd0, o_busy}, 32'd1);
        check("abort_no_done", {31'd0, o_done}, 32'd0);
        tick(1);
        check("abort_new_freq", {8'd0, o_freq}, 32'd110);
        check("abort_new_gate", {31'd0, o_gate}, 32'd1);
        tick(99);
        i_rst_n = 1'b0;
        #1;
        check("midrst_freq", {8'd0, o_freq}, 32'd1);
        check("midrst_gate", {31'd0, o_gate}, 32'd0);
        check("midrst_busy", {31'd0, o_busy}, 32'd0);
        check("midrst_done_pin", {31'd0, o_done}, 32'd0);
        tick(2);
        i_rst_n = 1'b1;
        tick(3);
        check("abort_total_done", done_cycles, 4);
        check("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
